imem_debug_loader: RTL
======================

Name: imem_debug_loader

Overview:
Byte-stream controller that loads programs into the MIPS pipeline instruction memory and sequences CPU execution (run, single-step, halt, pipeline reset). It sits between a UART receive/transmit pair and the CPU top level. It drives the existing inst_mem_wr_en / inst_mem_addr / inst_mem_data write port and adds CPU enable and reset control. Every command is answered with a single status byte on the TX side.

Parameters:
IMEM_DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; the maximum load length.
ACK_BYTE, 8'h06, status byte sent on success.
NAK_BYTE, 8'h15, status byte sent on an error or unknown command.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  received byte.
rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
tx_ready  input  1  transmitter can accept a byte this cycle.
tx_data  output  8  status byte to send.
tx_valid  output  1  tx_data is valid; held until tx_ready.
inst_mem_wr_en  output  1  instruction memory write strobe.
inst_mem_addr  output  32  byte address of the write, always word-aligned.
inst_mem_data  output  32  instruction word to write.
cpu_reset  output  1  pipeline reset pulse to the CPU.
cpu_enable  output  1  CPU clock-enable; when low the pipeline stalls.
cpu_halted  input  1  CPU has retired a HALT instruction; level signal.
cycle_count  output  32  number of cycles cpu_enable was high since the last cpu_reset pulse.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, word index 0, byte counter 0. Reset mid-operation aborts any load, run or send immediately. No partial word is written.
- States: IDLE, LEN_HI, LEN_LO, LOAD, WRITE, RUN, STEP, PRST, SEND.
- IDLE: on rx_valid, decode rx_data.
  - 8'h4C 'L' -> LEN_HI.
  - 8'h52 'R' -> RUN if cpu_halted==0, else SEND NAK.
  - 8'h53 'S' -> STEP.
  - 8'h50 'P' -> PRST.
  - Any other byte -> SEND NAK.
- LEN_HI / LEN_LO: capture the word count N as a 16-bit big-endian value over two rx bytes.
  - N==0 -> SEND ACK with no writes.
  - N>IMEM_DEPTH_WORDS -> SEND NAK.
  - Otherwise -> LOAD with index k=0.
- LOAD: shift in 4 rx bytes, MSB first. After the 4th byte -> WRITE.
- WRITE: exactly one cycle with inst_mem_wr_en=1, inst_mem_addr=4*k, inst_mem_data=assembled word. Then k increments.
  - k==N -> PRST, with the ACK queued.
  - Otherwise -> LOAD.
  - An rx byte arriving in the WRITE cycle is captured as the next byte; no byte is lost.
- cpu_enable is forced 0 in every state except RUN and STEP.
- RUN: cpu_enable=1 every cycle. Exit on whichever comes first:
  - cpu_halted==1 sampled: cpu_enable drops that same cycle (combinational gate), -> SEND ACK.
  - rx_valid with rx_data==8'h48 'H': cpu_enable=0 from the next cycle, -> SEND ACK.
  - Other rx bytes during RUN are dropped.
- STEP: cpu_enable=1 for exactly one cycle, then SEND ACK.
- PRST: cpu_reset=1 for exactly one cycle and cycle_count cleared to 0 in the same cycle, then SEND ACK.
- SEND: tx_valid=1, tx_data stable until the cycle where tx_ready=1 (the transfer), then IDLE. rx bytes arriving during SEND are dropped.
- cycle_count: increments by 1 on each cycle with cpu_enable=1 and saturates at 32'hFFFFFFFF.
- inst_mem_addr and inst_mem_data hold their last written values when inst_mem_wr_en=0.

Test Plan:
- Load 2 words: bytes 4C 00 02 3C 0B 00 F0 01 60 00 08.
  -> Write pulse addr 0 data 32'h3C0B00F0, then addr 4 data 32'h01600008, one cycle each.
  -> One cpu_reset pulse, then tx 8'h06.
- Oversize and unknown commands:
  - Bytes 4C 01 01 with IMEM_DEPTH_WORDS=256 -> no writes, tx 8'h15, back to IDLE.
  - Byte 8'h7A -> tx 8'h15.
- Run until halt: byte 52, cpu_halted rises after 37 enabled cycles.
  -> cpu_enable low that cycle, cycle_count==37, tx 8'h06.
- Step and break:
  - Bytes 53, 53 -> two isolated 1-cycle cpu_enable pulses, cycle_count==2, two ACKs.
  - 52 then 48 -> cpu_enable drops the cycle after 48, ACK.
- TX backpressure: hold tx_ready=0 for 10 cycles after an 'S' command.
  -> tx_valid held with 8'h06, then transfer on tx_ready, IDLE.
  -> A byte 52 sent during the wait is ignored.
- Reset mid-load: after 4C 00 03 and 6 data bytes, assert reset for 1 cycle.
  -> Exactly one write (addr 0) has occurred, all outputs 0.
  -> A subsequent fresh load starts at addr 0.

Source files
------------

// File: rtl/imem_debug_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_debug_loader_if
// Brief    : UART byte stream, instruction-memory write port and CPU control
//            bundle between the debug loader and its surroundings.
// Revision : 1.0
// ============================================================================
interface imem_debug_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        inst_mem_wr_en;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;
    logic        cpu_reset;
    logic        cpu_enable;
    logic        cpu_halted;
    logic [31:0] cycle_count;
    logic        busy;

    // master: the loader itself
    modport master (
        input  rx_data, rx_valid, tx_ready, cpu_halted,
        output tx_data, tx_valid, inst_mem_wr_en, inst_mem_addr, inst_mem_data,
               cpu_reset, cpu_enable, cycle_count, busy
    );

    // slave: UART pair and CPU top level
    modport slave (
        output rx_data, rx_valid, tx_ready, cpu_halted,
        input  tx_data, tx_valid, inst_mem_wr_en, inst_mem_addr, inst_mem_data,
               cpu_reset, cpu_enable, cycle_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_debug_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_debug_loader
// Brief    : Byte-command controller that loads instruction memory and runs,
//            steps, halts and resets the CPU; answers each command with a byte.
// Revision : 1.0
// ============================================================================
module imem_debug_loader #(
    parameter int         IMEM_DEPTH_WORDS = 256,
    parameter logic [7:0] ACK_BYTE         = 8'h06,
    parameter logic [7:0] NAK_BYTE         = 8'h15
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_debug_loader_if.master  bus
);
    localparam logic [3:0] c_st_idle   = 4'd0;
    localparam logic [3:0] c_st_len_hi = 4'd1;
    localparam logic [3:0] c_st_len_lo = 4'd2;
    localparam logic [3:0] c_st_load   = 4'd3;
    localparam logic [3:0] c_st_write  = 4'd4;
    localparam logic [3:0] c_st_run    = 4'd5;
    localparam logic [3:0] c_st_step   = 4'd6;
    localparam logic [3:0] c_st_prst   = 4'd7;
    localparam logic [3:0] c_st_send   = 4'd8;

    localparam logic [7:0]  c_cmd_load  = 8'h4C;
    localparam logic [7:0]  c_cmd_run   = 8'h52;
    localparam logic [7:0]  c_cmd_step  = 8'h53;
    localparam logic [7:0]  c_cmd_prst  = 8'h50;
    localparam logic [7:0]  c_cmd_halt  = 8'h48;
    localparam logic [16:0] c_depth     = 17'(IMEM_DEPTH_WORDS);

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic [7:0]  w_send_byte;
    logic [15:0] w_len;

    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [7:0]  r_tx_data;
    logic [31:0] r_cycle_count;

    logic        w_wr_en;
    logic        w_cpu_reset;
    logic        w_cpu_enable;
    logic        w_tx_valid;
    logic        w_busy;

    assign w_len = {r_len_hi, bus.rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_send_byte  = ACK_BYTE;
        case (r_state)
            c_st_idle: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        c_cmd_load: w_state_next = c_st_len_hi;
                        c_cmd_run: begin
                            if (bus.cpu_halted) begin
                                w_state_next = c_st_send;
                                w_send_byte  = NAK_BYTE;
                            end else begin
                                w_state_next = c_st_run;
                            end
                        end
                        c_cmd_step: w_state_next = c_st_step;
                        c_cmd_prst: w_state_next = c_st_prst;
                        default: begin
                            w_state_next = c_st_send;
                            w_send_byte  = NAK_BYTE;
                        end
                    endcase
                end
            end
            c_st_len_hi: begin
                if (bus.rx_valid) w_state_next = c_st_len_lo;
            end
            c_st_len_lo: begin
                if (bus.rx_valid) begin
                    if (w_len == 16'd0) begin
                        w_state_next = c_st_send;
                    end else if ({1'b0, w_len} > c_depth) begin
                        w_state_next = c_st_send;
                        w_send_byte  = NAK_BYTE;
                    end else begin
                        w_state_next = c_st_load;
                    end
                end
            end
            c_st_load: begin
                if (bus.rx_valid && r_byte_cnt == 2'd3) w_state_next = c_st_write;
            end
            c_st_write: begin
                // The last word hands over to a pipeline reset; its ACK follows.
                w_state_next = (r_idx + 16'd1 == r_len) ? c_st_prst : c_st_load;
            end
            c_st_run: begin
                if (bus.cpu_halted || (bus.rx_valid && bus.rx_data == c_cmd_halt)) begin
                    w_state_next = c_st_send;
                end
            end
            c_st_step: w_state_next = c_st_send;
            c_st_prst: w_state_next = c_st_send;
            c_st_send: begin
                if (bus.tx_ready) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_wr_en      = (r_state == c_st_write);
        w_cpu_reset  = (r_state == c_st_prst);
        // Halt gates the enable in the same cycle so no instruction retires past HALT.
        w_cpu_enable = (r_state == c_st_step) || ((r_state == c_st_run) && !bus.cpu_halted);
        w_tx_valid   = (r_state == c_st_send);
        w_busy       = (r_state != c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_hi      <= 8'd0;
            r_len         <= 16'd0;
            r_idx         <= 16'd0;
            r_byte_cnt    <= 2'd0;
            r_shift       <= 24'd0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_tx_data     <= 8'd0;
            r_cycle_count <= 32'd0;
        end else begin
            if (r_state != c_st_send && w_state_next == c_st_send) begin
                r_tx_data <= w_send_byte;
            end
            case (r_state)
                c_st_len_hi: begin
                    if (bus.rx_valid) r_len_hi <= bus.rx_data;
                end
                c_st_len_lo: begin
                    if (bus.rx_valid) begin
                        r_len      <= w_len;
                        r_idx      <= 16'd0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                c_st_load: begin
                    if (bus.rx_valid) begin
                        r_shift    <= {r_shift[15:0], bus.rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_data <= {r_shift, bus.rx_data};
                            r_addr <= {14'd0, r_idx, 2'b00};
                        end
                    end
                end
                c_st_write: begin
                    r_idx <= r_idx + 16'd1;
                    // A byte landing during the write is the first byte of the next word.
                    if (bus.rx_valid) begin
                        r_shift    <= {r_shift[15:0], bus.rx_data};
                        r_byte_cnt <= 2'd1;
                    end
                end
                default: ;
            endcase
            if (w_cpu_reset) begin
                r_cycle_count <= 32'd0;
            end else if (w_cpu_enable && r_cycle_count != 32'hFFFF_FFFF) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
        end
    end

    assign bus.tx_data        = r_tx_data;
    assign bus.tx_valid       = w_tx_valid;
    assign bus.inst_mem_wr_en = w_wr_en;
    assign bus.inst_mem_addr  = r_addr;
    assign bus.inst_mem_data  = r_data;
    assign bus.cpu_reset      = w_cpu_reset;
    assign bus.cpu_enable     = w_cpu_enable;
    assign bus.cycle_count    = r_cycle_count;
    assign bus.busy           = w_busy;
endmodule
`default_nettype wire
